rv_test_monitor: RTL and testbench

// Hardware pass/fail monitor for the riscv-tests (rv32ui-p-*) flow, instantiated in cpu_top_soc beside cpu_top.

---
 rtl/rv_test_monitor.sv | 133 +++++++++++++
 tb/tb_rv_test_monitor.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_test_monitor.sv
// Pass/fail monitor for riscv-tests: shadows x3/x26/x27 from the write-back port and
// latches the verdict a fixed settle window after the test signals completion via x26.
module rv_test_monitor #(
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_en,
    input  logic [4:0]       wb_rd,
    input  logic [31:0]      wb_data,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [31:0]      fail_testnum,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    // Shadow slots: 0 -> x3 (test number), 1 -> x26 (done flag), 2 -> x27 (result flag)
    localparam int NSH = 3;
    localparam logic [14:0] SH_IDX_PACK = {5'd27, 5'd26, 5'd3};

    typedef enum logic [1:0] {ST_RUN, ST_SETTLE, ST_DONE, ST_TIMEOUT} state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [31:0]      shadow_reg  [NSH];
    logic [31:0]      shadow_next [NSH];
    logic [SW-1:0]    settle_cnt_reg;
    logic [CNT_W-1:0] cycle_count_reg;
    logic             pass_reg;
    logic [31:0]      fail_testnum_reg;
    logic             trigger;
    logic             settle_last;
    logic             watchdog_hit;
    logic             result_ok;

    // Shadow registers; the _next view bypasses a write presented in the current cycle
    generate
        for (genvar gi = 0; gi < NSH; gi++) begin : g_shadow
            localparam logic [4:0] IDX = SH_IDX_PACK[gi*5 +: 5];

            assign shadow_next[gi] = (wb_en && (wb_rd == IDX)) ? wb_data : shadow_reg[gi];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    shadow_reg[gi] <= '0;
                end else begin
                    shadow_reg[gi] <= shadow_next[gi];
                end
            end
        end
    endgenerate

    // Only a write of x26 in this very cycle can trigger; a stale shadow value never does
    assign trigger     = wb_en && (wb_rd == 5'd26) && (shadow_next[1] == 32'd1);
    assign settle_last = (settle_cnt_reg == SETTLE_LAST);
    assign result_ok   = (shadow_next[2] == 32'd1);

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_wdog
            localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
            assign watchdog_hit = (cycle_count_reg == TIMEOUT_LAST);
        end else begin : g_no_wdog
            assign watchdog_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // A trigger coinciding with watchdog expiry takes priority
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RUN: begin
                if (trigger) begin
                    state_next = ST_SETTLE;
                end else if (watchdog_hit) begin
                    state_next = ST_TIMEOUT;
                end
            end
            ST_SETTLE: begin
                if (settle_last) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            settle_cnt_reg   <= '0;
            cycle_count_reg  <= '0;
            pass_reg         <= 1'b0;
            fail_testnum_reg <= '0;
        end else begin
            if ((state_reg == ST_RUN || state_reg == ST_SETTLE) && (cycle_count_reg != '1)) begin
                cycle_count_reg <= cycle_count_reg + CNT_W'(1);
            end
            if (state_reg == ST_RUN) begin
                settle_cnt_reg <= '0;
            end else if (state_reg == ST_SETTLE && !settle_last) begin
                settle_cnt_reg <= settle_cnt_reg + SW'(1);
            end
            if (state_reg == ST_SETTLE && settle_last) begin
                pass_reg         <= result_ok;
                fail_testnum_reg <= result_ok ? 32'd0 : shadow_next[0];
            end
        end
    end

    always_comb begin
        done         = (state_reg == ST_DONE);
        pass         = done && pass_reg;
        fail         = done && !pass_reg;
        timeout      = (state_reg == ST_TIMEOUT);
        fail_testnum = fail_testnum_reg;
        cycle_count  = cycle_count_reg;
    end

endmodule

// File: tb/tb_rv_test_monitor.sv
// Self-checking bench for rv_test_monitor: table-driven scenarios plus hand-written
// sequences for watchdog expiry and asynchronous reset.
module tb_rv_test_monitor;

    logic        clk;
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done;
    logic        pass;
    logic        fail;
    logic        timeout;
    logic [31:0] fail_testnum;
    logic [31:0] cycle_count;

    rv_test_monitor #(
        .SETTLE_CYCLES (10),
        .TIMEOUT_CYCLES(50),
        .CNT_W         (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .done        (done),
        .pass        (pass),
        .fail        (fail),
        .timeout     (timeout),
        .fail_testnum(fail_testnum),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          trig;       // edge number carrying the x26<=1 write
        logic [31:0] x3;
        logic [31:0] x27;
        int          late_off;   // extra write at edge trig+late_off; 0 = none
        logic [4:0]  late_rd;
        logic [31:0] late_data;
        logic        e_pass;
        logic [31:0] e_num;
    } vec_t;

    typedef struct {
        logic        pass;
        logic        fail;
        logic        tmo;
        logic [31:0] num;
        logic [31:0] cnt;
        int          edge_n;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        wb_en = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic drive_idle(input int ed);
        logic [4:0] rd;
        wb_en = 1'b0;
        case (ed % 3)
            0:       rd = 5'd3;
            1:       rd = 5'd26;
            default: rd = 5'd27;
        endcase
        wb_rd   = rd;
        wb_data = (rd == 5'd26) ? 32'd1 : $urandom;
    endtask

    task automatic drive_wr(input logic [4:0] rd, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_rd   = rd;
        wb_data = data;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, " unexpected result"}, 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        $display("[%0t] %s: done=%0b pass=%0b fail=%0b timeout=%0b num=%0d cnt=%0d edge=%0d",
                 $time, tag, done, pass, fail, timeout, fail_testnum, cycle_count, cyc);
        check({tag, " done"},         done,         e.pass | e.fail);
        check({tag, " pass"},         pass,         e.pass);
        check({tag, " fail"},         fail,         e.fail);
        check({tag, " timeout"},      timeout,      e.tmo);
        check({tag, " fail_testnum"}, fail_testnum, e.num);
        check({tag, " cycle_count"},  cycle_count,  e.cnt);
        check({tag, " latency edge"}, cyc,          e.edge_n);
    endtask

    task automatic run_vec(input vec_t v, input string tag, input bit with_reset);
        exp_t e;
        bit   seen;
        if (with_reset) do_reset();
        e.pass   = v.e_pass;
        e.fail   = !v.e_pass;
        e.tmo    = 1'b0;
        e.num    = v.e_num;
        e.cnt    = v.trig + 10;
        e.edge_n = v.trig + 10;
        seen     = 1'b0;
        for (int ed = 1; ed <= v.trig + 15; ed++) begin
            drive_idle(ed);
            if (ed == 2) drive_wr(5'd3, v.x3);
            if (ed == 3) drive_wr(5'd27, v.x27);
            if (ed == v.trig) begin
                drive_wr(5'd26, 32'd1);
                exp_q.push_back(e);
            end
            if (v.late_off != 0 && ed == v.trig + v.late_off) drive_wr(v.late_rd, v.late_data);
            step();
            if (!seen && (done || timeout)) begin
                seen = 1'b1;
                check_result(tag);
            end
        end
        wb_en = 1'b0;
        check({tag, " result seen"}, seen, 1'b1);
        if (!seen) exp_q.delete();
        check({tag, " frozen count"}, cycle_count, e.cnt);
        check({tag, " sticky pass"},  pass,        e.pass);
    endtask

    initial begin
        #500000;
        $display("FAIL global time limit: got no finish, expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        exp_t et;
        bit   seen;

        //          trig x3      x27     late rd    data    pass  num
        vecs[0] = '{20, 32'd5,  32'd1,  0,   5'd0,  32'd0,  1'b1, 32'd0};
        vecs[1] = '{15, 32'd7,  32'd0,  0,   5'd0,  32'd0,  1'b0, 32'd7};
        vecs[2] = '{10, 32'd9,  32'd0,  5,   5'd27, 32'd1,  1'b1, 32'd0};
        vecs[3] = '{10, 32'd9,  32'd0,  10,  5'd27, 32'd1,  1'b1, 32'd0};
        vecs[4] = '{12, 32'd11, 32'd1,  10,  5'd27, 32'd0,  1'b0, 32'd11};
        vecs[5] = '{12, 32'd11, 32'd0,  10,  5'd3,  32'd42, 1'b0, 32'd42};
        vecs[6] = '{8,  32'd4,  32'd1,  3,   5'd26, 32'd0,  1'b1, 32'd0};
        vecs[7] = '{50, 32'd2,  32'd1,  0,   5'd0,  32'd0,  1'b1, 32'd0};
        vecs[8] = '{25, 32'd6,  32'd2,  0,   5'd0,  32'd0,  1'b0, 32'd6};
        vecs[9] = '{10, 32'd3,  32'd0,  11,  5'd27, 32'd1,  1'b0, 32'd3};

        rst     = 1'b0;
        wb_en   = 1'b0;
        wb_rd   = '0;
        wb_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset done",         done,         1'b0);
        check("reset pass",         pass,         1'b0);
        check("reset fail",         fail,         1'b0);
        check("reset timeout",      timeout,      1'b0);
        check("reset fail_testnum", fail_testnum, 32'd0);
        check("reset cycle_count",  cycle_count,  32'd0);

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i), 1'b1);
        end

        // Watchdog: non-1 x26 write and an x0 write must not trigger
        do_reset();
        et.pass = 1'b0; et.fail = 1'b0; et.tmo = 1'b1; et.num = 32'd0; et.cnt = 32'd50; et.edge_n = 50;
        exp_q.push_back(et);
        seen = 1'b0;
        for (int ed = 1; ed <= 60; ed++) begin
            drive_idle(ed);
            if (ed == 5) drive_wr(5'd26, 32'd2);
            if (ed == 6) drive_wr(5'd0, 32'd1);
            if (ed == 55) drive_wr(5'd26, 32'd1);
            step();
            if (!seen && (done || timeout)) begin
                seen = 1'b1;
                check_result("timeout");
            end
        end
        wb_en = 1'b0;
        check("timeout seen",         seen,        1'b1);
        if (!seen) exp_q.delete();
        check("timeout frozen count", cycle_count, 32'd50);
        check("timeout sticky done",  done,        1'b0);
        #3 rst = 1'b0;
        #1;
        check("async rst timeout", timeout,     1'b0);
        check("async rst tmo cnt", cycle_count, 32'd0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of SETTLE
        do_reset();
        for (int ed = 1; ed <= 14; ed++) begin
            drive_idle(ed);
            if (ed == 4)  drive_wr(5'd27, 32'd1);
            if (ed == 10) drive_wr(5'd26, 32'd1);
            step();
        end
        wb_en = 1'b0;
        check("settle count before rst", cycle_count, 32'd14);
        #3 rst = 1'b0;
        #1;
        check("async rst settle count", cycle_count, 32'd0);
        check("async rst settle done",  done,        1'b0);
        check("async rst settle pass",  pass,        1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        run_vec(vecs[0], "rerun after rst", 1'b0);

        // Asynchronous reset while holding a fail verdict
        run_vec(vecs[1], "fail before rst", 1'b1);
        #3 rst = 1'b0;
        #1;
        check("async rst done",         done,         1'b0);
        check("async rst fail",         fail,         1'b0);
        check("async rst fail_testnum", fail_testnum, 32'd0);
        check("async rst cycle_count",  cycle_count,  32'd0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
